// File: rtl/water_pkg.sv
// Shared definitions for the tank water arbiter: state encoding and consumer ids.
`default_nettype none
package water_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        REGA  = 3'd2,
        LIMP  = 3'd3,
        FAULT = 3'd4
    } state_e;

    localparam logic RQ_REGA = 1'b0;
    localparam logic RQ_LIMP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/water_arbiter_if.sv
// Request, level-sensor and grant signals between the arbiter and its neighbours.
`default_nettype none
interface water_arbiter_if;
    logic       req_rega;
    logic       req_limp;
    logic       lvl_low;
    logic       lvl_high;
    logic       critico;
    logic       grant_rega;
    logic       grant_limp;
    logic       valve_in;
    logic       alarm;
    logic [2:0] state_o;

    modport slave (
        input  req_rega, req_limp, lvl_low, lvl_high, critico,
        output grant_rega, grant_limp, valve_in, alarm, state_o
    );

    modport master (
        output req_rega, req_limp, lvl_low, lvl_high, critico,
        input  grant_rega, grant_limp, valve_in, alarm, state_o
    );
endinterface
`default_nettype wire

// File: rtl/water_timer.sv
// Saturating slot/fill counter with dwell, slot-length and fill-timeout flags.
`default_nettype none
module water_timer #(
    parameter int CNT_W     = 5,
    parameter int DWELL     = 4,
    parameter int MAX_GRANT = 12,
    parameter int FILL_MAX  = 20
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      dwell_ok_o,
    output logic      slot_done_o,
    output logic      fill_to_o
);
    localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] SLOT_LIM  = CNT_W'(MAX_GRANT - 1);
    localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign dwell_ok_o  = (cnt_q >= DWELL_LIM);
    assign slot_done_o = (cnt_q >= SLOT_LIM);
    assign fill_to_o   = (cnt_q == FILL_LIM);
endmodule
`default_nettype wire

// File: rtl/water_arbiter.sv
// Moore FSM sharing the tank between irrigation and cleaning, with refill and fault handling.
`default_nettype none
module water_arbiter
    import water_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int DWELL     = 4,
    parameter int MAX_GRANT = 12,
    parameter int FILL_MAX  = 20
) (
    input  wire logic      clock,
    input  wire logic      reset,
    water_arbiter_if.slave bus_if
);
    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   cnt_clr, cnt_en;
    logic   dwell_ok, slot_done, fill_to;

    water_timer #(
        .CNT_W     (CNT_W),
        .DWELL     (DWELL),
        .MAX_GRANT (MAX_GRANT),
        .FILL_MAX  (FILL_MAX)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .dwell_ok_o  (dwell_ok),
        .slot_done_o (slot_done),
        .fill_to_o   (fill_to)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= RQ_LIMP;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus_if.req_rega || bus_if.req_limp) begin
                    if (bus_if.lvl_low)
                        state_d = FILL;
                    else if (bus_if.req_rega && bus_if.req_limp)
                        state_d = (last_q == RQ_REGA) ? LIMP : REGA;
                    else if (bus_if.req_rega)
                        state_d = REGA;
                    else
                        state_d = LIMP;
                end
            end
            FILL: begin
                if (bus_if.lvl_high)
                    state_d = IDLE;
                else if (fill_to)
                    state_d = FAULT;
            end
            REGA: begin
                // Low tank preempts without touching last, so rega keeps its turn.
                if (bus_if.lvl_low) begin
                    state_d = FILL;
                end else if ((!bus_if.req_rega && dwell_ok) ||
                             (bus_if.req_limp && slot_done)) begin
                    state_d = IDLE;
                    last_d  = RQ_REGA;
                end
            end
            LIMP: begin
                if (bus_if.lvl_low) begin
                    state_d = FILL;
                end else if ((!bus_if.req_limp && dwell_ok) ||
                             (bus_if.req_rega && slot_done)) begin
                    state_d = IDLE;
                    last_d  = RQ_LIMP;
                end
            end
            FAULT:   state_d = IDLE;
            default: state_d = FAULT;
        endcase

        // Faults override every per-state decision, including leaving FAULT.
        if (bus_if.critico || (bus_if.lvl_low && bus_if.lvl_high)) begin
            state_d = FAULT;
            last_d  = last_q;
        end

        cnt_clr = (state_d != state_q) || (state_q == IDLE) || (state_q == FAULT);
        cnt_en  = !cnt_clr;
    end

    assign bus_if.grant_rega = (state_q == REGA);
    assign bus_if.grant_limp = (state_q == LIMP);
    assign bus_if.valve_in   = (state_q == FILL);
    assign bus_if.alarm      = (state_q == FAULT);
    assign bus_if.state_o    = state_q;
endmodule
`default_nettype wire

// File: tb/tb_water_arbiter.sv
// Scoreboard bench for water_arbiter: stimulus queues expected states, a monitor checks each cycle.
`default_nettype none
module tb_water_arbiter;
    import water_pkg::*;

    logic clock;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [6:0] vec;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    water_arbiter_if wif();

    water_arbiter #(
        .CNT_W     (5),
        .DWELL     (4),
        .MAX_GRANT (12),
        .FILL_MAX  (20)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_if (wif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Output vector as {state, grant_rega, grant_limp, valve_in, alarm}.
    function automatic logic [6:0] exp_vec(input state_e s);
        return {s, s == REGA, s == LIMP, s == FILL, s == FAULT};
    endfunction

    function automatic logic [6:0] act_vec();
        return {wif.state_o, wif.grant_rega, wif.grant_limp, wif.valve_in, wif.alarm};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic rr, input logic rl,
                        input logic lo, input logic hi, input logic cr,
                        input state_e es, input string nm);
        @(negedge clock);
        reset        = rst_v;
        wif.req_rega = rr;
        wif.req_limp = rl;
        wif.lvl_low  = lo;
        wif.lvl_high = hi;
        wif.critico  = cr;
        exp_q.push_back('{exp_vec(es), nm});
        @(posedge clock);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check(nm, act_vec(), 7'b0);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.nm, act_vec(), e.vec);
        end
    end

    a_mutex: assert property (@(posedge clock)
        $onehot0({wif.grant_rega, wif.grant_limp, wif.valve_in}))
        else begin
            n_fail++;
            $display("FAIL mutex: rega=%b limp=%b valve=%b",
                     wif.grant_rega, wif.grant_limp, wif.valve_in);
        end

    initial begin
        reset        = 1'b0;
        wif.req_rega = 1'b1;
        wif.req_limp = 1'b1;
        wif.lvl_low  = 1'b0;
        wif.lvl_high = 1'b0;
        wif.critico  = 1'b0;
        #1 check("reset_outputs", act_vec(), 7'b0);

        step(0, 1, 1, 0, 0, 0, IDLE, "reset_hold");
        step(0, 1, 1, 0, 0, 0, IDLE, "reset_hold");
        step(1, 1, 0, 0, 0, 0, REGA, "first_grant");
        repeat (3) step(1, 0, 0, 0, 0, 0, REGA, "rega_dwell");
        step(1, 0, 0, 0, 0, 0, IDLE, "rega_release");

        // last=REGA, so limp wins the tie; then slots alternate every 12 cycles.
        step(1, 1, 1, 0, 0, 0, LIMP, "rr_limp_start");
        repeat (11) step(1, 1, 1, 0, 0, 0, LIMP, "rr_limp_slot");
        step(1, 1, 1, 0, 0, 0, IDLE, "rr_limp_revoke");
        step(1, 1, 1, 0, 0, 0, REGA, "rr_rega_start");
        repeat (11) step(1, 1, 1, 0, 0, 0, REGA, "rr_rega_slot");
        step(1, 1, 1, 0, 0, 0, IDLE, "rr_rega_revoke");
        step(1, 1, 1, 0, 0, 0, LIMP, "rr_limp_again");
        repeat (3) step(1, 0, 0, 0, 0, 0, LIMP, "rr_limp_dwell");
        step(1, 0, 0, 0, 0, 0, IDLE, "rr_limp_release");

        step(1, 0, 1, 0, 0, 0, LIMP, "pulse_grant");
        repeat (3) step(1, 0, 0, 0, 0, 0, LIMP, "pulse_dwell");
        step(1, 0, 0, 0, 0, 0, IDLE, "pulse_release");

        // Preemption by low level: rega keeps priority over waiting limp.
        step(1, 1, 0, 0, 0, 0, REGA, "pre_grant");
        step(1, 1, 1, 1, 0, 0, FILL, "pre_fill");
        repeat (5) step(1, 1, 1, 1, 0, 0, FILL, "pre_filling");
        step(1, 1, 1, 0, 1, 0, IDLE, "pre_full");
        step(1, 1, 1, 0, 0, 0, REGA, "pre_regrant");
        repeat (3) step(1, 0, 0, 0, 0, 0, REGA, "pre_dwell");
        step(1, 0, 0, 0, 0, 0, IDLE, "pre_release");

        step(1, 1, 0, 1, 0, 0, FILL, "to_fill");
        repeat (19) step(1, 1, 0, 1, 0, 0, FILL, "fill_wait");
        step(1, 1, 0, 1, 0, 0, FAULT, "fill_timeout");
        step(1, 0, 0, 0, 0, 1, FAULT, "fault_hold");
        step(1, 0, 0, 0, 0, 0, IDLE, "fault_exit");

        step(1, 0, 1, 0, 0, 0, LIMP, "crit_grant");
        step(1, 0, 1, 0, 0, 0, LIMP, "crit_grant_hold");
        step(1, 0, 1, 0, 0, 1, FAULT, "crit_trip");
        step(1, 0, 0, 0, 0, 0, IDLE, "crit_exit");
        step(1, 0, 0, 1, 1, 0, FAULT, "sensor_trip");
        step(1, 0, 0, 1, 1, 0, FAULT, "sensor_hold");
        step(1, 0, 0, 0, 0, 0, IDLE, "sensor_exit");

        step(1, 1, 0, 0, 0, 0, REGA, "mid_grant");
        async_reset("async_reset_grant");
        step(0, 1, 0, 0, 0, 0, IDLE, "reset_grant_hold");
        step(1, 1, 0, 1, 0, 0, FILL, "mid_fill");
        async_reset("async_reset_fill");
        step(0, 1, 1, 0, 0, 0, IDLE, "reset_fill_hold");
        step(1, 1, 1, 0, 0, 0, REGA, "post_reset_tie");

        @(posedge clock);
        #2 check("queue_drain", 7'(exp_q.size()), 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/water_arbiter.md
Name: water_arbiter

Overview:
- Moore FSM that shares the single tank water supply between two consumers: irrigation (rega) and cleaning (limp).
- Grants at most one consumer at a time, with round-robin fairness and a bounded slot length.
- Refills the tank through the inlet valve whenever the tank reads low, and trips to a fault state on critical or sensor errors.
- Sits between the level sensors / request sources and the per-function consumer FSMs.

Parameters:
- CNT_W, 5, width of the internal cycle counter.
- DWELL, 4, minimum cycles a grant is held before a voluntary release is honoured.
- MAX_GRANT, 12, cycles after which a grant is revoked if the other requester is waiting.
- FILL_MAX, 20, fill timeout in cycles before declaring a fault.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_rega, input, 1, irrigation request (level).
- req_limp, input, 1, cleaning request (level).
- lvl_low, input, 1, tank below low mark.
- lvl_high, input, 1, tank at full mark.
- critico, input, 1, critical fault from the system.
- grant_rega, output, 1, irrigation may draw water.
- grant_limp, output, 1, cleaning may draw water.
- valve_in, output, 1, inlet valve open.
- alarm, output, 1, fault indicator.
- state_o, output, 3, current state code.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, last=LIMP (so rega wins the first tie). All outputs are 0.
- All outputs are decoded from the registered state only, with no input-to-output path:
  - grant_rega=1 only in REGA.
  - grant_limp=1 only in LIMP.
- State codes: IDLE=3'd0, FILL=3'd1, REGA=3'd2, LIMP=3'd3, FAULT=3'd4. Codes 5-7 go to FAULT.
- Global priority, evaluated in every state, first match wins:
  - critico=1 -> FAULT.
  - lvl_low=1 and lvl_high=1 -> FAULT (inconsistent sensors).
- IDLE:
  - No request -> stay in IDLE.
  - Any request and lvl_low -> FILL.
  - Otherwise grant the single requester.
  - Both requesting -> grant the one not equal to last.
  - cnt cleared on every exit.
- FILL:
  - cnt increments each cycle.
  - lvl_high=1 -> IDLE.
  - cnt==FILL_MAX-1 with lvl_high=0 -> FAULT (timeout).
- REGA / LIMP:
  - cnt increments each cycle, saturating at all-ones.
  - lvl_low=1 -> FILL immediately. This is a preemption: DWELL is not required and last is not updated, so the interrupted requester regains priority.
  - Own request low and cnt>=DWELL-1 -> IDLE; last is set to this consumer.
  - Own request low and cnt<DWELL-1 -> hold the grant (minimum dwell).
  - Other request high and cnt>=MAX_GRANT-1 -> IDLE; last is set to this consumer, so the other is served next.
- FAULT:
  - alarm=1; valve_in and both grants 0.
  - Exit to IDLE on the first cycle where critico=0 and the sensors are consistent.
  - cnt cleared.
- Transition latency: the output reflects a decision one clock after the inputs are sampled.
- Reset asserted mid-grant or mid-fill forces all outputs to 0 immediately, without waiting for a clock edge.
- Mutual exclusion: grant_rega, grant_limp and valve_in are one-hot-or-zero in every cycle. This must be checked with an assertion.

Decomposition:
- Shared package water_pkg holds:
  - the state encoding localparams (IDLE, FILL, REGA, LIMP, FAULT);
  - the consumer-id constants RQ_REGA=1'b0 and RQ_LIMP=1'b1, used for last.
- One natural sub-module: water_timer, a CNT_W-bit counter with clear/enable, saturation, and compare flags for dwell_ok, slot_done and fill_to. The FSM instantiates it once.

Test Plan:
- Reset with reset=0, all requests high -> all outputs 0 and state_o=0. After reset=1 with req_rega=1 -> grant_rega=1 at the 2nd edge.
- Both requests held, lvl_low=0 -> rega granted for 12 cycles, then LIMP granted for 12 cycles, alternating; never both grants high.
- req_limp pulsed for 1 cycle while in IDLE -> grant_limp held exactly 4 cycles (DWELL), then back to IDLE.
- During REGA, drive lvl_low=1 for 6 cycles, then lvl_high=1 -> FILL with valve_in=1, then IDLE, then rega re-granted ahead of a waiting limp.
- In FILL, hold lvl_high=0 -> FAULT with alarm=1 after 20 cycles. Clear critico/sensors -> IDLE next edge.
- Assert critico=1 mid-LIMP -> FAULT next edge with grant_limp=0. Also drive lvl_low=lvl_high=1 in IDLE -> FAULT.
